// File: rtl/pool_fmap_buffer.sv
// Ping-pong frame buffer between the max-pool stage and its consumer.
// Two banks with full flags; the read side streams a committed bank through a skid.
module pool_fmap_buffer #(
  parameter int DATA_WIDTH = 32,
  parameter int OUT_WIDTH  = 28,
  parameter int OUT_HEIGHT = 28
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  valid_in,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  done_in,
  output logic                  ack,
  input  logic                  rd_ready,
  output logic                  valid_out,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  last_out,
  output logic                  overflow
);

  localparam int DEPTH = OUT_WIDTH * OUT_HEIGHT;
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    RELEASE
  } rd_state_e;

  logic [DATA_WIDTH-1:0] mem_q [2][DEPTH];

  logic [1:0]            full_q, full_d;
  logic                  wr_bank_q;
  logic [AW-1:0]         wr_addr_q, wr_addr_d;
  logic [CW-1:0]         cnt_q [2];
  logic                  pend_q, pend_d;
  logic                  ovf_q;
  rd_state_e             state_q, state_d;
  logic                  rd_bank_q, rd_bank_d;
  logic [CW-1:0]         rd_addr_q, rd_addr_d;
  logic                  rvalid_q, rlast_q, rlast_d;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  out_v_q, out_v_d, out_l_q, out_l_d;
  logic [DATA_WIDTH-1:0] out_d_q, out_d_d;
  logic                  sk_v_q, sk_v_d, sk_l_q, sk_l_d;
  logic [DATA_WIDTH-1:0] sk_d_q, sk_d_d;

  logic          wr_en, commit, pop, space, issue, rel, rbank;
  logic [AW-1:0] raddr;
  logic [1:0]    occ;

  assign wr_en  = valid_in && !full_q[wr_bank_q];
  assign commit = wr_en && (done_in || wr_addr_q == AW'(DEPTH - 1));
  assign ack    = pend_q && !full_q[wr_bank_q];
  assign pop    = out_v_q && rd_ready;

  // Words already held or in flight after this cycle's pop; keep at most two.
  assign occ   = 2'(out_v_q) + 2'(sk_v_q) + 2'(rvalid_q) - 2'(pop);
  assign space = occ <= 2'd1;

  assign valid_out = out_v_q;
  assign data_out  = out_d_q;
  assign last_out  = out_l_q;
  assign overflow  = ovf_q;

  always_comb begin
    wr_addr_d = wr_addr_q;
    if (commit) wr_addr_d = '0;
    else if (wr_en) wr_addr_d = wr_addr_q + AW'(1);
    pend_d = commit | (pend_q & ~ack);
  end

  always_comb begin
    state_d   = state_q;
    rd_bank_d = rd_bank_q;
    rd_addr_d = rd_addr_q;
    issue     = 1'b0;
    rel       = 1'b0;
    rbank     = rd_bank_q;
    raddr     = '0;
    unique case (state_q)
      IDLE: begin
        if (full_q[rd_bank_q] && space) begin
          issue     = 1'b1;
          rd_addr_d = CW'(1);
          state_d   = STREAM;
        end
      end
      STREAM: begin
        if (rd_addr_q != cnt_q[rd_bank_q] && space) begin
          issue     = 1'b1;
          raddr     = rd_addr_q[AW-1:0];
          rd_addr_d = rd_addr_q + CW'(1);
        end
        if (pop && out_l_q) state_d = RELEASE;
      end
      RELEASE: begin
        rel       = 1'b1;
        rd_bank_d = ~rd_bank_q;
        rbank     = ~rd_bank_q;
        rd_addr_d = '0;
        state_d   = IDLE;
        // Chain straight into the other bank to keep frame gaps short.
        if (full_q[~rd_bank_q]) begin
          issue     = 1'b1;
          rd_addr_d = CW'(1);
          state_d   = STREAM;
        end
      end
      default: state_d = IDLE;
    endcase
    rlast_d = (CW'(raddr) + CW'(1)) == cnt_q[rbank];
  end

  always_comb begin
    full_d = full_q;
    if (rel) full_d[rd_bank_q] = 1'b0;
    if (commit) full_d[wr_bank_q] = 1'b1;
  end

  always_comb begin
    out_v_d = out_v_q;
    out_d_d = out_d_q;
    out_l_d = out_l_q;
    sk_v_d  = sk_v_q;
    sk_d_d  = sk_d_q;
    sk_l_d  = sk_l_q;
    if (pop) begin
      out_v_d = sk_v_q;
      out_d_d = sk_d_q;
      out_l_d = sk_l_q;
      sk_v_d  = 1'b0;
    end
    if (rvalid_q) begin
      if (!out_v_d) begin
        out_v_d = 1'b1;
        out_d_d = rdata_q;
        out_l_d = rlast_q;
      end else begin
        sk_v_d = 1'b1;
        sk_d_d = rdata_q;
        sk_l_d = rlast_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_bank_q][wr_addr_q] <= data_in;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      full_q    <= '0;
      wr_bank_q <= 1'b0;
      wr_addr_q <= '0;
      cnt_q[0]  <= '0;
      cnt_q[1]  <= '0;
      pend_q    <= 1'b0;
      ovf_q     <= 1'b0;
      state_q   <= IDLE;
      rd_bank_q <= 1'b0;
      rd_addr_q <= '0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rdata_q   <= '0;
      out_v_q   <= 1'b0;
      out_d_q   <= '0;
      out_l_q   <= 1'b0;
      sk_v_q    <= 1'b0;
      sk_d_q    <= '0;
      sk_l_q    <= 1'b0;
    end else begin
      full_q    <= full_d;
      wr_addr_q <= wr_addr_d;
      pend_q    <= pend_d;
      state_q   <= state_d;
      rd_bank_q <= rd_bank_d;
      rd_addr_q <= rd_addr_d;
      rvalid_q  <= issue;
      out_v_q   <= out_v_d;
      out_d_q   <= out_d_d;
      out_l_q   <= out_l_d;
      sk_v_q    <= sk_v_d;
      sk_d_q    <= sk_d_d;
      sk_l_q    <= sk_l_d;
      if (valid_in && full_q[wr_bank_q]) ovf_q <= 1'b1;
      if (commit) begin
        cnt_q[wr_bank_q] <= CW'(wr_addr_q) + CW'(1);
        wr_bank_q        <= ~wr_bank_q;
      end
      if (issue) begin
        rdata_q <= mem_q[rbank][raddr];
        rlast_q <= rlast_d;
      end
    end
  end

endmodule

// File: tb/tb_pool_fmap_buffer.sv
// Scoreboard bench for pool_fmap_buffer with a 2x2 map (four-word banks).
// Writer follows the ack protocol; a negedge monitor checks order and holds.
module tb_pool_fmap_buffer;

  localparam int DW    = 32;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          valid_in = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic          done_in = 1'b0;
  logic          rd_ready = 1'b0;
  logic          ack, valid_out, last_out, overflow;
  logic [DW-1:0] data_out;

  pool_fmap_buffer #(
    .DATA_WIDTH(DW),
    .OUT_WIDTH (2),
    .OUT_HEIGHT(2)
  ) dut (
    .clk      (clk),
    .resetn   (resetn),
    .valid_in (valid_in),
    .data_in  (data_in),
    .done_in  (done_in),
    .ack      (ack),
    .rd_ready (rd_ready),
    .valid_out(valid_out),
    .data_out (data_out),
    .last_out (last_out),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0] d;
    logic          l;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   checks = 0;
  int   errors = 0;
  int   ack_cnt = 0;
  int   exp_acks = 0;
  int   rd_mode = 0;
  int   pat = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // Downstream ready: 0 low, 1 high, 2 pattern 1,0,0, 3 random.
  always @(posedge clk) begin
    #1;
    case (rd_mode)
      0: rd_ready = 1'b0;
      1: rd_ready = 1'b1;
      2: begin
        rd_ready = (pat % 3 == 0);
        pat++;
      end
      default: rd_ready = 1'($urandom_range(0, 1));
    endcase
  end

  logic          pv = 1'b0, pr = 1'b0, pl = 1'b0, pa = 1'b0;
  logic [DW-1:0] pd = '0;

  always @(negedge clk) begin
    if (!resetn) begin
      ack_cnt = 0;
      pv = 1'b0;
      pa = 1'b0;
    end else begin
      if (pv && !pr) begin
        chk("hold_valid", 32'(valid_out), 32'd1);
        chk("hold_data", data_out, pd);
        chk("hold_last", 32'(last_out), 32'(pl));
      end
      if (pa) chk("ack_width", 32'(ack), 32'd0);
      if (ack) ack_cnt++;
      if (valid_out && rd_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra_word actual=%0h required=none", data_out);
        end else begin
          e = exp_q.pop_front();
          chk("data", data_out, e.d);
          chk("last", 32'(last_out), 32'(e.l));
        end
      end
      pv = valid_out;
      pr = rd_ready;
      pd = data_out;
      pl = last_out;
      pa = ack;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [DW-1:0] d, input logic dn);
    valid_in = 1'b1;
    data_in  = d;
    done_in  = dn;
    cyc();
    valid_in = 1'b0;
    done_in  = 1'b0;
  endtask

  task automatic send(input int base, input int len, input bit rnd,
                      input bit push, input bit gaps);
    for (int i = 0; i < len; i++) begin
      logic [DW-1:0] d;
      logic          dn;
      d  = rnd ? $urandom : 32'(base + i);
      dn = 1'b0;
      if (i == len - 1)
        dn = (len < DEPTH) ? 1'b1 : 1'($urandom_range(0, 1));
      if (gaps)
        while ($urandom_range(0, 2) == 0) begin
          done_in = 1'($urandom_range(0, 1));
          cyc();
          done_in = 1'b0;
        end
      wr(d, dn);
      if (push) exp_q.push_back('{d: d, l: (i == len - 1)});
    end
    if (push) exp_acks++;
  endtask

  task automatic wait_ack();
    int n = 0;
    while (ack_cnt < exp_acks && n < 200) begin
      cyc();
      n++;
    end
    chk("ack_count", 32'(ack_cnt), 32'(exp_acks));
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      cyc();
      n++;
    end
    chk("drain", 32'(exp_q.size()), 32'd0);
    repeat (4) cyc();
  endtask

  task automatic chk_reset_outs();
    chk("rst_valid", 32'(valid_out), 32'd0);
    chk("rst_last", 32'(last_out), 32'd0);
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_data", data_out, 32'd0);
  endtask

  initial begin
    #2;
    chk_reset_outs();
    repeat (3) cyc();
    resetn = 1'b1;
    cyc();

    // Single frame, ack timing and one word per cycle.
    rd_mode = 1;
    send(1, 4, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    chk("ack_next", 32'(ack), 32'd1);
    @(negedge clk);
    @(negedge clk);
    chk("first_valid", 32'(valid_out), 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stream_rate", 32'(valid_out), 32'd1);
    end
    wait_drain();
    wait_ack();

    // Backpressure.
    rd_mode = 2;
    pat = 0;
    send(1, 4, 1'b0, 1'b1, 1'b0);
    wait_drain();
    wait_ack();

    // Short frame.
    rd_mode = 1;
    send(7, 2, 1'b0, 1'b1, 1'b0);
    wait_drain();
    wait_ack();

    // Ping-pong with overflow.
    rd_mode = 0;
    repeat (2) cyc();
    send(10, 4, 1'b0, 1'b1, 1'b0);
    send(20, 4, 1'b0, 1'b1, 1'b0);
    repeat (3) cyc();
    chk("pp_ack_held", 32'(ack_cnt), 32'(exp_acks - 1));
    chk("pp_no_ovf", 32'(overflow), 32'd0);
    send(30, 4, 1'b0, 1'b0, 1'b0);
    cyc();
    chk("pp_ovf", 32'(overflow), 32'd1);
    rd_mode = 1;
    wait_drain();
    wait_ack();
    chk("ovf_sticky", 32'(overflow), 32'd1);

    // Reset mid-stream.
    send(1, 4, 1'b0, 1'b1, 1'b0);
    for (int n = 0; n < 50 && exp_q.size() > 2; n++) cyc();
    chk("mid_two_out", 32'(exp_q.size()), 32'd2);
    resetn = 1'b0;
    #1;
    chk_reset_outs();
    exp_q.delete();
    exp_acks = 0;
    repeat (3) cyc();
    resetn = 1'b1;
    cyc();
    send(5, 4, 1'b0, 1'b1, 1'b0);
    wait_drain();
    wait_ack();

    // Random frames, gaps, stray done_in and random ready.
    rd_mode = 3;
    for (int f = 0; f < 25; f++) begin
      send(0, $urandom_range(1, DEPTH), 1'b1, 1'b1, 1'b1);
      wait_ack();
    end
    wait_drain();
    chk("rand_no_ovf", 32'(overflow), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
